// File: rtl/panel_cmd_sequencer.sv
// Purpose: decodes the UART byte stream into LED-panel colour, pixel, run and clear commands.
// Latency: all outputs registered; pixel writes start the cycle after the coordinate byte, one per cycle.
// Backpressure: none; a byte arriving during a run is dropped and reported as an overrun.
module panel_cmd_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_dv,
    output logic       fb_we,
    output logic [3:0] fb_col,
    output logic [2:0] fb_row,
    output logic       fb_val,
    output logic       fb_clear,
    output logic [2:0] rgb,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OVERRUN = 2'b00;
    localparam logic [1:0] ERR_UNKNOWN = 2'b01;
    localparam logic [1:0] ERR_ABORT   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT_COORD, RUN} state_t;

    state_t        state_q, state_d;

    // Latched command context: run length, pixel value, start column, write index, timeout count.
    logic [4:0]    len_q, len_d;
    logic          val_q, val_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    k_q, k_d;
    logic [TW-1:0] tmo_q, tmo_d;

    // Next values of the registered outputs.
    logic          fb_we_d, fb_val_d, fb_clear_d, busy_d, err_d;
    logic [3:0]    fb_col_d;
    logic [2:0]    fb_row_d, rgb_d;
    logic [1:0]    err_code_d;

    logic [3:0]    op;
    logic          op_draw;
    logic [4:0]    run_sum;
    logic          last_wr;
    logic          tmo_exp;

    assign op      = rx_data[7:4];
    assign op_draw = (op == 4'h1) || (op == 4'h2) || (op == 4'h4) || (op == 4'h5);
    // Column sum is 5 bits so the clip at column 15 can never wrap back to 0.
    assign run_sum = {1'b0, col_q} + {1'b0, k_q};
    assign last_wr = (({1'b0, k_q} + 5'd1) == len_q) || (run_sum == 5'd15);
    assign tmo_exp = (tmo_q == TMO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decision; an incoming byte on the expiry cycle wins over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_dv && op_draw) state_d = WAIT_COORD;
            end
            WAIT_COORD: begin
                if (rx_dv)        state_d = rx_data[7] ? IDLE : RUN;
                else if (tmo_exp) state_d = IDLE;
            end
            RUN: begin
                if (last_wr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for outputs and the command context.
    always_comb begin
        fb_we_d    = 1'b0;
        fb_clear_d = 1'b0;
        err_d      = 1'b0;
        fb_col_d   = fb_col;
        fb_row_d   = fb_row;
        fb_val_d   = fb_val;
        rgb_d      = rgb;
        err_code_d = err_code;
        len_d      = len_q;
        val_d      = val_q;
        col_d      = col_q;
        k_d        = k_q;
        tmo_d      = tmo_q;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (rx_dv) begin
                    case (op)
                        4'h0: rgb_d = rx_data[2:0];
                        4'h1: begin len_d = 5'd1; val_d = 1'b1; end
                        4'h2: begin len_d = 5'd1; val_d = 1'b0; end
                        4'h3: fb_clear_d = 1'b1;
                        4'h4: begin len_d = {1'b0, rx_data[3:0]} + 5'd1; val_d = 1'b1; end
                        4'h5: begin len_d = {1'b0, rx_data[3:0]} + 5'd1; val_d = 1'b0; end
                        4'hF: ;
                        default: begin err_d = 1'b1; err_code_d = ERR_UNKNOWN; end
                    endcase
                end
            end
            WAIT_COORD: begin
                if (rx_dv) begin
                    if (rx_data[7]) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ABORT;
                    end else begin
                        col_d    = rx_data[3:0];
                        k_d      = 4'd0;
                        fb_we_d  = 1'b1;
                        fb_row_d = rx_data[6:4];
                        fb_col_d = rx_data[3:0];
                        fb_val_d = val_q;
                    end
                end else if (tmo_exp) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            RUN: begin
                if (rx_dv) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_OVERRUN;
                end
                if (!last_wr) begin
                    fb_we_d  = 1'b1;
                    k_d      = k_q + 4'd1;
                    fb_col_d = run_sum[3:0] + 4'd1;
                end
            end
            default: ;
        endcase
    end

    // Output and context registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb_we    <= 1'b0;
            fb_col   <= 4'd0;
            fb_row   <= 3'd0;
            fb_val   <= 1'b0;
            fb_clear <= 1'b0;
            rgb      <= 3'b111;
            busy     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            len_q    <= 5'd1;
            val_q    <= 1'b0;
            col_q    <= 4'd0;
            k_q      <= 4'd0;
            tmo_q    <= '0;
        end else begin
            fb_we    <= fb_we_d;
            fb_col   <= fb_col_d;
            fb_row   <= fb_row_d;
            fb_val   <= fb_val_d;
            fb_clear <= fb_clear_d;
            rgb      <= rgb_d;
            busy     <= busy_d;
            err      <= err_d;
            err_code <= err_code_d;
            len_q    <= len_d;
            val_q    <= val_d;
            col_q    <= col_d;
            k_q      <= k_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_panel_cmd_sequencer.sv
// Bench for panel_cmd_sequencer: directed and random byte streams checked against an event-level model.
// Each scenario is a fixed window of cycles; every output is compared every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_panel_cmd_sequencer;

    localparam int T = 8;
    localparam int W = 48;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       fb_we;
    logic [3:0] fb_col;
    logic [2:0] fb_row;
    logic       fb_val;
    logic       fb_clear;
    logic [2:0] rgb;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;

    // Scenario schedule and expected event tables.
    bit         sdv [W];
    logic [7:0] sb  [W];
    bit         e_we [W];
    int         e_row [W];
    int         e_col [W];
    int         e_val [W];
    bit         e_err [W];
    int         e_errc [W];
    bit         e_clr [W];
    bit         e_busy [W];
    bit         e_rgbchg [W];
    int         e_rgbv [W];

    // Persistent expected state carried across scenarios.
    int m_rgb  = 7;
    int m_code = 0;

    logic [7:0] rb;

    always #5 clk = ~clk;

    panel_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_dv    (rx_dv),
        .fb_we    (fb_we),
        .fb_col   (fb_col),
        .fb_row   (fb_row),
        .fb_val   (fb_val),
        .fb_clear (fb_clear),
        .rgb      (rgb),
        .busy     (busy),
        .err      (err),
        .err_code (err_code)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sched();
        for (int i = 0; i < W; i++) begin
            sdv[i] = 1'b0;
            sb[i]  = 8'h00;
        end
    endtask

    task automatic put(input int t, input logic [7:0] b);
        sdv[t] = 1'b1;
        sb[t]  = b;
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i <= b; i++)
            if (i < W) e_busy[i] = 1'b1;
    endtask

    // Event-level model: walks arrivals in time order, tracking only the pending
    // command, its opcode time and the cycle at which the current run ends.
    task automatic model();
        bit         pend;
        int         pt, plen, pval, bfrom, run_end, n, row, col;
        logic [7:0] b;
        pend = 1'b0; pt = 0; plen = 1; pval = 0; bfrom = 0; run_end = -1;
        for (int i = 0; i < W; i++) begin
            e_we[i] = 0; e_row[i] = 0; e_col[i] = 0; e_val[i] = 0;
            e_err[i] = 0; e_errc[i] = 0; e_clr[i] = 0; e_busy[i] = 0;
            e_rgbchg[i] = 0; e_rgbv[i] = 0;
        end
        for (int t = 0; t < W; t++) begin
            if (pend && t == pt + T + 1) begin
                e_err[t] = 1; e_errc[t] = 3;
                mark_busy(bfrom, t - 1);
                pend = 1'b0;
            end
            if (sdv[t]) begin
                b = sb[t];
                if (t <= run_end) begin
                    e_err[t+1] = 1; e_errc[t+1] = 0;
                end else if (pend) begin
                    if (b[7]) begin
                        e_err[t+1] = 1; e_errc[t+1] = 2;
                        mark_busy(bfrom, t);
                    end else begin
                        row = int'(b[6:4]);
                        col = int'(b[3:0]);
                        n   = (plen < 16 - col) ? plen : 16 - col;
                        for (int k = 0; k < n; k++) begin
                            e_we[t+1+k]  = 1;
                            e_row[t+1+k] = row;
                            e_col[t+1+k] = col + k;
                            e_val[t+1+k] = pval;
                        end
                        run_end = t + n;
                        mark_busy(bfrom, t + n);
                    end
                    pend = 1'b0;
                end else begin
                    case (int'(b[7:4]))
                        0: begin e_rgbchg[t+1] = 1; e_rgbv[t+1] = int'(b[2:0]); end
                        1, 2, 4, 5: begin
                            pend  = 1'b1;
                            pt    = t;
                            bfrom = t + 1;
                            plen  = (b[7:4] >= 4'h4) ? int'(b[3:0]) + 1 : 1;
                            pval  = (b[7:4] == 4'h1 || b[7:4] == 4'h4) ? 1 : 0;
                        end
                        3:  e_clr[t+1] = 1;
                        15: ;
                        default: begin e_err[t+1] = 1; e_errc[t+1] = 1; end
                    endcase
                end
            end
        end
    endtask

    // Drives the schedule for W cycles and compares every output each cycle.
    task automatic run_scn(input string name);
        int rg, cd;
        rg = m_rgb;
        cd = m_code;
        model();
        for (int i = 0; i < W; i++) begin
            rx_dv   = sdv[i];
            rx_data = sdv[i] ? sb[i] : 8'($urandom_range(0, 255));
            @(negedge clk);
            if (e_rgbchg[i]) rg = e_rgbv[i];
            if (e_err[i])    cd = e_errc[i];
            chk($sformatf("%s.fb_we@%0d", name, i),    32'(fb_we),    32'(e_we[i]));
            chk($sformatf("%s.err@%0d", name, i),      32'(err),      32'(e_err[i]));
            chk($sformatf("%s.err_code@%0d", name, i), 32'(err_code), 32'(cd));
            chk($sformatf("%s.fb_clear@%0d", name, i), 32'(fb_clear), 32'(e_clr[i]));
            chk($sformatf("%s.busy@%0d", name, i),     32'(busy),     32'(e_busy[i]));
            chk($sformatf("%s.rgb@%0d", name, i),      32'(rgb),      32'(rg));
            if (e_we[i]) begin
                chk($sformatf("%s.fb_row@%0d", name, i), 32'(fb_row), 32'(e_row[i]));
                chk($sformatf("%s.fb_col@%0d", name, i), 32'(fb_col), 32'(e_col[i]));
                chk($sformatf("%s.fb_val@%0d", name, i), 32'(fb_val), 32'(e_val[i]));
            end
            step();
        end
        rx_dv  = 1'b0;
        m_rgb  = rg;
        m_code = cd;
    endtask

    initial begin
        reset   = 1'b1;
        rx_dv   = 1'b0;
        rx_data = 8'h00;
        step();
        step();
        @(negedge clk);
        chk("rst.fb_we",    32'(fb_we),    32'd0);
        chk("rst.fb_col",   32'(fb_col),   32'd0);
        chk("rst.fb_row",   32'(fb_row),   32'd0);
        chk("rst.fb_val",   32'(fb_val),   32'd0);
        chk("rst.fb_clear", 32'(fb_clear), 32'd0);
        chk("rst.rgb",      32'(rgb),      32'd7);
        chk("rst.busy",     32'(busy),     32'd0);
        chk("rst.err",      32'(err),      32'd0);
        chk("rst.err_code", 32'(err_code), 32'd0);
        step();
        reset = 1'b0;

        clear_sched(); put(0, 8'h05);                                   run_scn("rgb");
        clear_sched(); put(0, 8'h10); put(2, 8'h37);                    run_scn("single_set");
        clear_sched(); put(0, 8'h47); put(1, 8'h2C);                    run_scn("clipped_run");
        clear_sched(); put(0, 8'h5F); put(1, 8'h00); put(6, 8'h03);     run_scn("run_clear_overrun");
        clear_sched(); put(0, 8'h80);                                   run_scn("unknown_op");
        clear_sched(); put(0, 8'h20); put(1, 8'hF5);                    run_scn("abort");
        clear_sched(); put(0, 8'h10);                                   run_scn("timeout");
        clear_sched(); put(0, 8'h10); put(T, 8'h37);                    run_scn("expiry_edge");
        clear_sched(); put(0, 8'h10); put(T + 1, 8'h37);                run_scn("late_coord");
        clear_sched(); put(0, 8'h10); put(1, 8'h37); put(3, 8'h4F); put(4, 8'h7E);
                       put(7, 8'h30); put(8, 8'hF0); put(9, 8'h0B);     run_scn("back_to_back");
        clear_sched(); put(0, 8'h2A); put(1, 8'h0F); put(2, 8'h11);     run_scn("last_write_overrun");

        for (int s = 0; s < 40; s++) begin
            clear_sched();
            for (int t = 0; t < 24; t++) begin
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 4))
                        0: rb = {4'h4 | 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
                        1: rb = {4'($urandom_range(1, 2)), 4'($urandom_range(0, 15))};
                        2: rb = {1'b0, 7'($urandom_range(0, 127))};
                        default: rb = 8'($urandom_range(0, 255));
                    endcase
                    put(t, rb);
                end
            end
            run_scn($sformatf("rnd%0d", s));
        end

        // Reset in the middle of a 16-pixel run after three writes.
        rx_dv = 1'b1; rx_data = 8'h4F; step();
        rx_dv = 1'b1; rx_data = 8'h00; step();
        rx_dv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_rst.fb_we@%0d", k),  32'(fb_we),  32'd1);
            chk($sformatf("mid_rst.fb_col@%0d", k), 32'(fb_col), 32'(k));
            chk($sformatf("mid_rst.busy@%0d", k),   32'(busy),   32'd1);
            if (k == 2) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        m_rgb = 7;
        m_code = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst.fb_we@%0d", k), 32'(fb_we), 32'd0);
            chk($sformatf("post_rst.busy@%0d", k),  32'(busy),  32'd0);
            chk($sformatf("post_rst.err@%0d", k),   32'(err),   32'd0);
            if (k == 0) chk("post_rst.rgb", 32'(rgb), 32'd7);
            step();
        end

        clear_sched(); put(0, 8'h12); put(1, 8'h45);                    run_scn("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
